// File: rtl/ps2_kbd_pkg.sv
// Shared scancode constants, prefix states and fill default for the PS/2 line editor.
// The shifted-digit helper is used only when KBD_SHIFT_EN is defined.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] FILL_DEF  = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } pfx_e;

  function automatic logic [7:0] shift_digit(
    input logic [7:0] d
  );
    logic [7:0] r;
    r = d;
    case (d)
      8'h31:   r = 8'h21;
      8'h32:   r = 8'h40;
      8'h33:   r = 8'h23;
      8'h34:   r = 8'h24;
      8'h35:   r = 8'h25;
      8'h36:   r = 8'h5E;
      8'h37:   r = 8'h26;
      8'h38:   r = 8'h2A;
      8'h39:   r = 8'h28;
      8'h30:   r = 8'h29;
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational scancode-set-2 to ASCII lookup.
// KBD_SHIFT_EN selects lowercase/uppercase letters and shifted digit symbols.
module ps2_scan_to_ascii
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic       hit,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic       is_letter;
  logic       is_digit;

  always_comb begin
    hit  = 1'b1;
    base = 8'h00;
    case (code)
      8'h1C: base = 8'h41;
      8'h32: base = 8'h42;
      8'h21: base = 8'h43;
      8'h23: base = 8'h44;
      8'h24: base = 8'h45;
      8'h2B: base = 8'h46;
      8'h34: base = 8'h47;
      8'h33: base = 8'h48;
      8'h43: base = 8'h49;
      8'h3B: base = 8'h4A;
      8'h42: base = 8'h4B;
      8'h4B: base = 8'h4C;
      8'h3A: base = 8'h4D;
      8'h31: base = 8'h4E;
      8'h44: base = 8'h4F;
      8'h4D: base = 8'h50;
      8'h15: base = 8'h51;
      8'h2D: base = 8'h52;
      8'h1B: base = 8'h53;
      8'h2C: base = 8'h54;
      8'h3C: base = 8'h55;
      8'h2A: base = 8'h56;
      8'h1D: base = 8'h57;
      8'h22: base = 8'h58;
      8'h35: base = 8'h59;
      8'h1A: base = 8'h5A;
      8'h45: base = 8'h30;
      8'h16: base = 8'h31;
      8'h1E: base = 8'h32;
      8'h26: base = 8'h33;
      8'h25: base = 8'h34;
      8'h2E: base = 8'h35;
      8'h36: base = 8'h36;
      8'h3D: base = 8'h37;
      8'h3E: base = 8'h38;
      8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      default: hit = 1'b0;
    endcase
  end

  assign is_letter = (base >= 8'h41) && (base <= 8'h5A);
  assign is_digit  = (base >= 8'h30) && (base <= 8'h39);

`ifdef KBD_SHIFT_EN
  always_comb begin
    ascii = base;
    if (is_letter && !shift)
      ascii = base | 8'h20;
    else if (is_digit && shift)
      ascii = shift_digit(base);
  end
`else
  logic unused_sel;
  assign unused_sel = shift ^ is_letter ^ is_digit;
  assign ascii      = base;
`endif

endmodule

// File: rtl/ps2_line_buffer.sv
// PS/2 set-2 line editor: prefix FSM, live line buffer, Enter capture.
// Define KBD_SHIFT_EN to track shift and produce lowercase/shifted symbols.
module ps2_line_buffer
  import ps2_kbd_pkg::*;
#(
  parameter  int         CHARS = 16,
  parameter  logic [7:0] FILL  = FILL_DEF,
  localparam int         LW    = $clog2(CHARS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [7:0]           data,
  output logic [8*CHARS-1:0]   out_data,
  output logic [LW-1:0]        len,
  output logic                 full,
  output logic [8*CHARS-1:0]   line_out,
  output logic                 line_done
);

  localparam int W = 8 * CHARS;
  localparam logic [LW-1:0] LEN_MAX = LW'(CHARS);
  localparam logic [W-1:0]  BLANK   = {CHARS{FILL}};

  pfx_e           state_q, state_d;
  logic [W-1:0]   line_q, line_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [LW-1:0]  len_q, len_d;
  logic           full_q, full_d;
  logic           done_q, done_d;
  logic           shift_q;
  logic           hit;
  logic [7:0]     ascii;

`ifdef KBD_SHIFT_EN
  logic shift_d;
  logic is_shift;
  assign is_shift = (data == SC_LSHIFT) || (data == SC_RSHIFT);
`else
  assign shift_q = 1'b0;
`endif

  ps2_scan_to_ascii u_lut (
    .code  (data),
    .shift (shift_q),
    .hit   (hit),
    .ascii (ascii)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    lo_d    = lo_q;
    len_d   = len_q;
    done_d  = 1'b0;
`ifdef KBD_SHIFT_EN
    shift_d = shift_q;
`endif
    if (valid) begin
      unique case (1'b1)
        data == SC_EXT: state_d = EXT;
        data == SC_BRK:
          state_d = (state_q == EXT) ? EXT_BRK : BRK;
        default: begin
          state_d = IDLE;
          unique case (state_q)
            IDLE: begin
              unique case (1'b1)
                data == SC_BKSP: begin
                  if (len_q != '0) begin
                    line_d = {FILL, line_q[W-1:8]};
                    len_d  = len_q - 1'b1;
                  end
                end
                data == SC_ESC: begin
                  line_d = BLANK;
                  len_d  = '0;
                end
                data == SC_ENTER: begin
                  lo_d   = line_q;
                  done_d = 1'b1;
                  line_d = BLANK;
                  len_d  = '0;
                end
`ifdef KBD_SHIFT_EN
                is_shift: shift_d = 1'b1;
`endif
                hit: begin
                  if (!full_q) begin
                    line_d = {line_q[W-9:0], ascii};
                    len_d  = len_q + 1'b1;
                  end
                end
                default: ;
              endcase
            end
            BRK: begin
`ifdef KBD_SHIFT_EN
              if (is_shift)
                shift_d = 1'b0;
`endif
            end
            default: ;
          endcase
        end
      endcase
    end
    full_d = (len_d == LEN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= BLANK;
      lo_q    <= BLANK;
      len_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      lo_q    <= lo_d;
      len_q   <= len_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

`ifdef KBD_SHIFT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shift_q <= 1'b0;
    else
      shift_q <= shift_d;
  end
`endif

  assign out_data  = line_q;
  assign len       = len_q;
  assign full      = full_q;
  assign line_out  = lo_q;
  assign line_done = done_q;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Bench for ps2_line_buffer (CHARS=4): vector table, corner sequences,
// and random byte streams checked against a queue-based line model.
module tb_ps2_line_buffer;

  localparam int CHARS = 4;
  localparam int W     = 8 * CHARS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid = 1'b0;
  logic [7:0]     data = 8'h00;
  logic [W-1:0]   out_data;
  logic [W-1:0]   line_out;
  logic [2:0]     len;
  logic           full;
  logic           line_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_line_buffer #(.CHARS(CHARS)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .data      (data),
    .out_data  (out_data),
    .len       (len),
    .full      (full),
    .line_out  (line_out),
    .line_done (line_done)
  );

  typedef struct {
    logic [7:0]   code;
    logic [W-1:0] line;
    int           n;
    logic         f;
    logic         d;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tv[$];

  logic [7:0] letter_sc[26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc[10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] digit_sym[10] = '{
    8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  logic [7:0] misc_sc[11] = '{
    8'h29, 8'h66, 8'h76, 8'h5A, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h0E,
    8'h75, 8'h6B};

  logic [7:0]   q[$];
  logic         ext_m, brk_m, shift_m, done_m;
  logic [W-1:0] lo_m;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [W-1:0] eo, int el,
                           logic ef, logic ed, logic [W-1:0] elo);
    chk({tag, " out_data"}, out_data, eo);
    chk({tag, " len"}, 32'(len), 32'(el));
    chk({tag, " full"}, 32'(full), 32'(ef));
    chk({tag, " line_done"}, 32'(line_done), 32'(ed));
    chk({tag, " line_out"}, line_out, elo);
  endtask

  task automatic tick(logic v, logic [7:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    ext_m   = 1'b0;
    brk_m   = 1'b0;
    shift_m = 1'b0;
    done_m  = 1'b0;
    lo_m    = {CHARS{8'h20}};
  endtask

  function automatic logic [W-1:0] pack_line();
    logic [W-1:0] r;
    for (int i = 0; i < CHARS; i++)
      r[8*i +: 8] = (i < q.size()) ? q[q.size()-1-i] : 8'h20;
    return r;
  endfunction

  function automatic int lookup(logic [7:0] b);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == b)
`ifdef KBD_SHIFT_EN
        return shift_m ? 32'h41 + i : 32'h61 + i;
`else
        return 32'h41 + i;
`endif
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == b)
`ifdef KBD_SHIFT_EN
        return shift_m ? 32'(digit_sym[i]) : 32'h30 + i;
`else
        return 32'h30 + i;
`endif
    if (b == 8'h29)
      return 32'h20;
    return -1;
  endfunction

  task automatic model_make(logic [7:0] b);
    int a;
    a = lookup(b);
    if (b == 8'h66) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (b == 8'h76) begin
      q.delete();
    end else if (b == 8'h5A) begin
      lo_m   = pack_line();
      done_m = 1'b1;
      q.delete();
    end
`ifdef KBD_SHIFT_EN
    else if (b == 8'h12 || b == 8'h59) shift_m = 1'b1;
`endif
    else if (a >= 0 && q.size() < CHARS) begin
      q.push_back(a[7:0]);
    end
  endtask

  task automatic model_step(logic [7:0] b);
    if (b == 8'hE0) begin
      ext_m = 1'b1;
      brk_m = 1'b0;
    end else if (b == 8'hF0) begin
      if (!(ext_m && !brk_m)) ext_m = 1'b0;
      brk_m = 1'b1;
    end else begin
      if (!ext_m && brk_m) begin
`ifdef KBD_SHIFT_EN
        if (b == 8'h12 || b == 8'h59) shift_m = 1'b0;
`endif
      end else if (!ext_m && !brk_m) begin
        model_make(b);
      end
      ext_m = 1'b0;
      brk_m = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       v;
    do_reset();
    check_all("reset", 32'h20202020, 0, 1'b0, 1'b0, 32'h20202020);

`ifndef KBD_SHIFT_EN
    tv.push_back('{8'h1C, 32'h20202041, 1, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h32, 32'h20204142, 2, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h21, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'hF0, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h1C, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'hE0, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h75, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'hE0, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'hF0, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h75, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h0E, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h12, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h1C, 32'h41424341, 4, 1'b1, 1'b0, 32'h20202020});
    tv.push_back('{8'h1C, 32'h41424341, 4, 1'b1, 1'b0, 32'h20202020});
    tv.push_back('{8'h66, 32'h20414243, 3, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h66, 32'h20204142, 2, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h76, 32'h20202020, 0, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h66, 32'h20202020, 0, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h33, 32'h20202048, 1, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h43, 32'h20204849, 2, 1'b0, 1'b0, 32'h20202020});
    tv.push_back('{8'h5A, 32'h20202020, 0, 1'b0, 1'b1, 32'h20204849});
    tv.push_back('{8'h66, 32'h20202020, 0, 1'b0, 1'b0, 32'h20204849});
    tv.push_back('{8'h45, 32'h20202030, 1, 1'b0, 1'b0, 32'h20204849});
    tv.push_back('{8'h29, 32'h20203020, 2, 1'b0, 1'b0, 32'h20204849});
    tv.push_back('{8'h5A, 32'h20202020, 0, 1'b0, 1'b1, 32'h20203020});
    tv.push_back('{8'h5A, 32'h20202020, 0, 1'b0, 1'b1, 32'h20202020});
    for (int i = 0; i < tv.size(); i++) begin
      tick(1'b1, tv[i].code);
      check_all($sformatf("vec%0d", i), tv[i].line, tv[i].n,
                tv[i].f, tv[i].d, tv[i].lo);
    end

    tick(1'b1, 8'h1C);
    tick(1'b0, 8'h1C);
    check_all("idle_valid0", 32'h20202041, 1, 1'b0, 1'b0, 32'h20202020);
    tick(1'b1, 8'h5A);
    tick(1'b0, 8'h00);
    check_all("done_pulse_end", 32'h20202020, 0, 1'b0, 1'b0, 32'h20202041);
`else
    tick(1'b1, 8'h1C);
    chk("sh_lower", out_data, 32'h20202061);
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h1C);
    chk("sh_upper", out_data, 32'h20206141);
    tick(1'b1, 8'h16);
    chk("sh_bang", out_data, 32'h20614121);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h1C);
    chk("sh_release", out_data, 32'h61412161);
    chk("sh_full", 32'(full), 32'd1);
`endif

    tick(1'b1, 8'hF0);
    rst = 1'b1;
    #2;
    check_all("async_rst", 32'h20202020, 0, 1'b0, 1'b0, 32'h20202020);
    do_reset();
    tick(1'b1, 8'h1C);
`ifdef KBD_SHIFT_EN
    chk("rst_prefix", out_data, 32'h20202061);
`else
    chk("rst_prefix", out_data, 32'h20202041);
`endif
    chk("rst_prefix_len", 32'(len), 32'd1);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 2) == 0)
          b = digit_sc[$urandom_range(0, 9)];
        else
          b = letter_sc[$urandom_range(0, 25)];
      end else begin
        b = misc_sc[$urandom_range(0, 10)];
      end
      tick(v, b);
      done_m = 1'b0;
      if (v) model_step(b);
      check_all($sformatf("rnd%0d", n), pack_line(), q.size(),
                q.size() == CHARS, done_m, lo_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
